// File: rtl/serial_twos_decoder.sv
// serial_twos_decoder
//   Bit-serial receiver for LSB-first two's-complement words. The word is
//   returned in parallel, in sign-magnitude form. The magnitude of a negative
//   word uses the carry-free negation rule: copy bits up to and including the
//   first 1, then invert every higher bit. Both the raw word and its negation
//   build up during reception, so the last bit only has to pick one of them.
//
// Parameters
//   WIDTH          word length in bits including the sign (2..32)
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   bit_valid_i    bit_i is valid this cycle
//   bit_i          serial data bit, LSB first, sign bit last
//   frame_start_i  marks bit_i as bit 0 of a new word (with bit_valid_i)
//   out_ready_i    downstream accepts the result
//   out_valid_o    mag_o/sign_o hold a completed word
//   mag_o          unsigned magnitude |value|
//   sign_o         1 = negative
//   busy_o         word reception in progress
//   frame_err_o    one-cycle pulse on a framing violation
//   overrun_o      one-cycle pulse when a bit is dropped while a result waits
module serial_twos_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid_i,
  input  logic             bit_i,
  input  logic             frame_start_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] mag_o,
  output logic             sign_o,
  output logic             busy_o,
  output logic             frame_err_o,
  output logic             overrun_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     count;
  logic [WIDTH-1:0]  raw;
  logic [WIDTH-1:0]  neg;
  logic              seen_one;

  logic              take_first;
  logic              take_next;
  logic              last_bit;
  logic              err_nxt;
  logic              ovr_nxt;
  logic [CW-1:0]     idx;
  logic              seen_eff;

  // Select the sign-magnitude magnitude on the sign bit. For a negative word
  // the top magnitude bit follows the same copy/invert rule as the rest; for
  // the most negative value no 1 has been seen yet, so the MSB stays set.
  function automatic logic [WIDTH-1:0] sm_mag(
    input logic             b,
    input logic             seen,
    input logic [WIDTH-2:0] raw_low,
    input logic [WIDTH-2:0] neg_low
  );
    if (b) begin
      return {b ^ seen, neg_low};
    end
    return {b, raw_low};
  endfunction

  assign last_bit = (count == CW'(WIDTH - 1));
  assign busy_o   = (state == SHIFT);

  // A new frame always restarts at index 0 with no 1 seen yet, whatever the
  // aborted or completed previous word left behind.
  assign idx      = take_first ? '0 : count;
  assign seen_eff = take_first ? 1'b0 : seen_one;

  always_comb begin
    state_nxt  = state;
    take_first = 1'b0;
    take_next  = 1'b0;
    err_nxt    = 1'b0;
    ovr_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (bit_valid_i) begin
          if (frame_start_i) begin
            take_first = 1'b1;
            state_nxt  = SHIFT;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (bit_valid_i) begin
          if (frame_start_i) begin
            take_first = 1'b1;
            err_nxt    = 1'b1;
          end else begin
            take_next = 1'b1;
            if (last_bit) begin
              state_nxt = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          state_nxt = IDLE;
          if (bit_valid_i && frame_start_i) begin
            take_first = 1'b1;
            state_nxt  = SHIFT;
          end else if (bit_valid_i) begin
            // Handshake completes, but a non-start bit arrives with no frame
            // open: treated like a stray bit in IDLE.
            err_nxt = 1'b1;
          end
        end else if (bit_valid_i) begin
          ovr_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      raw         <= '0;
      neg         <= '0;
      seen_one    <= 1'b0;
      mag_o       <= '0;
      sign_o      <= 1'b0;
      out_valid_o <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_err_o <= err_nxt;
      overrun_o   <= ovr_nxt;

      // Bit capture: raw copy and running negation side by side
      if (take_first || take_next) begin
        raw[idx]  <= bit_i;
        neg[idx]  <= bit_i ^ seen_eff;
        seen_one  <= seen_eff | bit_i;
        count     <= (take_next && last_bit) ? '0 : idx + 1'b1;
      end

      // Result register: loaded on the sign bit, cleared valid on handshake
      if (take_next && last_bit) begin
        sign_o      <= bit_i;
        mag_o       <= sm_mag(bit_i, seen_one, raw[WIDTH-2:0], neg[WIDTH-2:0]);
        out_valid_o <= 1'b1;
      end else if (state == HOLD && out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_twos_decoder.sv
module tb_serial_twos_decoder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             bit_valid_i;
  logic             bit_i;
  logic             frame_start_i;
  logic             out_ready_i;
  logic             out_valid_o;
  logic [WIDTH-1:0] mag_o;
  logic             sign_o;
  logic             busy_o;
  logic             frame_err_o;
  logic             overrun_o;

  int nchk;
  int nerr;
  int fe_cnt;
  int ov_cnt;
  int fe_base;
  int ov_base;

  serial_twos_decoder #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .bit_valid_i   (bit_valid_i),
    .bit_i         (bit_i),
    .frame_start_i (frame_start_i),
    .out_ready_i   (out_ready_i),
    .out_valid_o   (out_valid_o),
    .mag_o         (mag_o),
    .sign_o        (sign_o),
    .busy_o        (busy_o),
    .frame_err_o   (frame_err_o),
    .overrun_o     (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (frame_err_o) fe_cnt++;
    if (overrun_o)   ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs);
    bit_valid_i   = 1'b1;
    bit_i         = b;
    frame_start_i = fs;
    tick();
    bit_valid_i   = 1'b0;
    frame_start_i = 1'b0;
    bit_i         = 1'b0;
  endtask

  // Send a whole word LSB first with up to gapmax idle cycles between bits,
  // then check the presented result.
  task automatic send_word(input string tag, input logic [7:0] v, input int gapmax,
                           input logic exp_sign, input logic [7:0] exp_mag);
    for (int i = 0; i < WIDTH; i++) begin
      if (i > 0) begin
        repeat ($urandom_range(gapmax, 0)) begin
          tick();
          chk({tag, "_gap_busy"}, 32'(busy_o), 32'd1);
        end
      end
      send_bit(v[i], i == 0);
      if (i < WIDTH - 1) begin
        chk({tag, "_busy"},  32'(busy_o), 32'd1);
        chk({tag, "_nvld"},  32'(out_valid_o), 32'd0);
      end
    end
    chk({tag, "_vld"},  32'(out_valid_o), 32'd1);
    chk({tag, "_busy0"}, 32'(busy_o), 32'd0);
    chk({tag, "_sign"}, 32'(sign_o), 32'(exp_sign));
    chk({tag, "_mag"},  32'(mag_o), 32'(exp_mag));
  endtask

  initial begin
    nchk = 0; nerr = 0; fe_cnt = 0; ov_cnt = 0;
    reset = 1'b1; bit_valid_i = 1'b0; bit_i = 1'b0;
    frame_start_i = 1'b0; out_ready_i = 1'b0;
    tick(); tick();
    chk("rst_vld",  32'(out_valid_o), 32'd0);
    chk("rst_mag",  32'(mag_o), 32'd0);
    chk("rst_sign", 32'(sign_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_fe",   32'(frame_err_o), 32'd0);
    chk("rst_ov",   32'(overrun_o), 32'd0);
    reset = 1'b0;
    out_ready_i = 1'b1;
    tick();

    // 1: +5, single word
    send_word("w05", 8'h05, 0, 1'b0, 8'h05);
    tick();
    chk("w05_idle_vld",  32'(out_valid_o), 32'd0);
    chk("w05_idle_busy", 32'(busy_o), 32'd0);

    // 2: back-to-back -5, -128, 0
    fe_base = fe_cnt; ov_base = ov_cnt;
    send_word("wfb", 8'hFB, 0, 1'b1, 8'h05);
    send_word("w80", 8'h80, 0, 1'b1, 8'h80);
    send_word("w00", 8'h00, 0, 1'b0, 8'h00);
    tick();
    chk("b2b_vld_done", 32'(out_valid_o), 32'd0);
    chk("b2b_fe", 32'(fe_cnt - fe_base), 32'd0);
    chk("b2b_ov", 32'(ov_cnt - ov_base), 32'd0);

    // 3: -42 with random gaps
    send_word("wd6", 8'hD6, 3, 1'b1, 8'h2A);
    tick();

    // 4: abort after 5 bits, restart with 0x7F
    fe_base = fe_cnt;
    send_bit(1'b1, 1'b1);
    for (int i = 1; i < 5; i++) send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    chk("abort_fe_pulse", 32'(frame_err_o), 32'd1);
    chk("abort_busy", 32'(busy_o), 32'd1);
    for (int i = 1; i < WIDTH; i++) send_bit((i < 7) ? 1'b1 : 1'b0, 1'b0);
    chk("abort_vld",  32'(out_valid_o), 32'd1);
    chk("abort_sign", 32'(sign_o), 32'd0);
    chk("abort_mag",  32'(mag_o), 32'h7F);
    chk("abort_fe_cnt", 32'(fe_cnt - fe_base), 32'd1);
    tick();

    // 5: -1 held with out_ready low while two bits arrive
    out_ready_i = 1'b0;
    ov_base = ov_cnt; fe_base = fe_cnt;
    send_word("wff", 8'hFF, 0, 1'b1, 8'h01);
    for (int c = 0; c < 4; c++) begin
      if (c == 0 || c == 2) send_bit(1'b1, 1'b0);
      else tick();
      chk("hold_vld",  32'(out_valid_o), 32'd1);
      chk("hold_sign", 32'(sign_o), 32'd1);
      chk("hold_mag",  32'(mag_o), 32'h01);
    end
    chk("hold_ov_cnt", 32'(ov_cnt - ov_base), 32'd2);
    chk("hold_fe_cnt", 32'(fe_cnt - fe_base), 32'd0);
    out_ready_i = 1'b1;
    tick();
    chk("hs_vld",     32'(out_valid_o), 32'd0);
    chk("hs_mag_ret", 32'(mag_o), 32'h01);
    chk("hs_sign_ret", 32'(sign_o), 32'd1);

    // 6: reset mid-frame, then 0x01, then a stray bit in IDLE
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    reset = 1'b1;
    bit_valid_i = 1'b1; bit_i = 1'b1; frame_start_i = 1'b1;
    tick();
    bit_valid_i = 1'b0; bit_i = 1'b0; frame_start_i = 1'b0;
    chk("mrst_vld",  32'(out_valid_o), 32'd0);
    chk("mrst_mag",  32'(mag_o), 32'd0);
    chk("mrst_sign", 32'(sign_o), 32'd0);
    chk("mrst_busy", 32'(busy_o), 32'd0);
    chk("mrst_fe",   32'(frame_err_o), 32'd0);
    chk("mrst_ov",   32'(overrun_o), 32'd0);
    reset = 1'b0;
    tick();
    fe_base = fe_cnt;
    send_word("w01", 8'h01, 0, 1'b0, 8'h01);
    chk("w01_fe", 32'(fe_cnt - fe_base), 32'd0);
    tick();
    send_bit(1'b1, 1'b0);
    chk("stray_fe",   32'(frame_err_o), 32'd1);
    chk("stray_vld",  32'(out_valid_o), 32'd0);
    chk("stray_busy", 32'(busy_o), 32'd0);
    tick();
    chk("stray_fe_end", 32'(frame_err_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/serial_twos_decoder.md
Name: serial_twos_decoder

Overview:
Bit-serial receiver that accepts an LSB-first two's-complement word one bit per qualified cycle. It outputs the word in parallel, in sign-magnitude form. It is the decode end of the team's bit-serial negation path: it recovers magnitude and sign without a parallel adder, using the same carry-free "copy until first 1, then invert" rule. The parallel result is presented over a valid/ready handshake to downstream logic.

Parameters:
WIDTH, 8, word length in bits including sign; legal range 2..32.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
bit_valid_i  input  1  bit_i is valid this cycle
bit_i  input  1  serial data bit, LSB first, MSB (sign) last
frame_start_i  input  1  qualifies bit_i as bit 0 of a new word (only meaningful with bit_valid_i)
out_ready_i  input  1  downstream accepts result
out_valid_o  output  1  mag_o/sign_o hold a completed word
mag_o  output  WIDTH  unsigned magnitude |value|
sign_o  output  1  1 = negative
busy_o  output  1  word reception in progress (state SHIFT)
frame_err_o  output  1  one-cycle pulse: protocol violation, see below
overrun_o  output  1  one-cycle pulse: bit dropped while result pending

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE; count=0; raw, neg, mag_o = 0; seen_one=0.
  - sign_o, out_valid_o, busy_o, frame_err_o, overrun_o all 0.
  - Reset overrides every other input in the same cycle, including mid-frame; a partial word is discarded.
- Accepted bit = bit_valid_i=1 in a state that consumes it.
- Per accepted bit b at index k (k=0 at frame start):
  - raw[k] <= b.
  - neg[k] <= b XOR seen_one, where seen_one is the value before this bit.
  - seen_one <= seen_one OR b.
  - At k=0, seen_one is treated as 0 regardless of its prior value.
- States:
  - IDLE:
    - bit_valid_i & frame_start_i: consume bit 0, count<=1, go SHIFT.
    - bit_valid_i & !frame_start_i: bit dropped, frame_err_o pulses.
  - SHIFT (busy_o=1):
    - bit_valid_i & !frame_start_i: consume bit at index count.
    - If count==WIDTH-1 (last bit), register the result and go HOLD:
      - sign_o <= b.
      - mag_o <= b ? {b XOR seen_one, neg[WIDTH-2:0]} : {b, raw[WIDTH-2:0]} (i.e. neg word vs raw word).
      - out_valid_o <= 1.
    - bit_valid_i & frame_start_i: abort current word, frame_err_o pulses, consume bit as bit 0 of a new word (count<=1), stay SHIFT.
    - No bit_valid_i: hold all state; gaps of any length are legal.
  - HOLD (out_valid_o=1; mag_o/sign_o stable until handshake):
    - out_ready_i=1: handshake completes this cycle. Next state IDLE, out_valid_o<=0; mag_o/sign_o retain their last value.
    - Same cycle also out_ready_i & bit_valid_i & frame_start_i: consume bit 0, go SHIFT directly (zero-bubble back-to-back).
    - bit_valid_i without a same-cycle handshake: bit dropped, overrun_o pulses, no state change.
- Latency: out_valid_o rises on the clock edge that consumes the last bit; it is visible the cycle after the MSB is presented. Minimum word period is WIDTH cycles.
- Most negative value -2^(WIDTH-1): sign_o=1, mag_o=2^(WIDTH-1) (MSB set). This is representable in WIDTH unsigned bits; no overflow flag.
- Zero: sign_o=0, mag_o=0. Negative zero cannot occur.
- frame_err_o and overrun_o are mutually exclusive, registered, and high for exactly one cycle per event.

Test Plan:
All scenarios use WIDTH=8, with bits sent back-to-back unless noted.
1. Send 0x05 LSB-first (1,0,1,0,0,0,0,0) with frame_start on the first bit, out_ready_i=1 -> out_valid_o high one cycle after the 8th bit, sign_o=0, mag_o=0x05; back to IDLE next cycle.
2. Send 0xFB (-5), then 0x80 (-128), then 0x00 back-to-back with zero bubbles -> results sign=1/mag=0x05, sign=1/mag=0x80, sign=0/mag=0x00. No frame_err_o or overrun_o.
3. Send 0xD6 (-42) with random 0-3 cycle gaps between bits -> sign_o=1, mag_o=0x2A. busy_o high throughout the frame.
4. Send 5 bits of a word, then assert frame_start_i with a new word 0x7F -> frame_err_o pulses once; result sign=0, mag_o=0x7F.
5. Complete 0xFF (-1) with out_ready_i low for 4 cycles while bit_valid_i pulses twice -> overrun_o pulses twice; sign_o=1, mag_o=0x01 stable throughout. Handshake completes when out_ready_i rises.
6. Assert reset after 3 bits of a word, then send 0x01 -> all outputs 0 during reset, partial word discarded, next result sign=0/mag=0x01. Also: bit_valid_i without frame_start_i in IDLE -> frame_err_o pulse, no output.
